// File: rtl/xc_rf_wb_arb.sv
// rtl/xc_rf_wb_arb.sv - register-file writeback arbiter for pipeline and coprocessor
//
// Merges pipeline writebacks and buffered coprocessor writebacks onto a single
// registered register-file write port. The pipeline has priority, but the
// coprocessor FIFO head is forced through after STARVE_LIMIT consecutive losses.
//
// Ports:
//   clock, resetn                          clock, asynchronous active-low reset
//   p_valid/p_ready, p_addr, p_wdata       pipeline writeback
//   c_valid/c_ready, c_wide, c_addr,
//   c_wdata, c_wdata_hi                    coprocessor writeback (2-entry FIFO)
//   rd_wen, rd_wide, rd_addr,
//   rd_wdata, rd_wdata_hi                  register-file write port (registered)
//   rs1_addr/rs2_addr -> rs1/rs2_hazard    uncommitted-write query
//   wide_misalign                          sticky: wide write had odd address
//
// Build option: XC_RF_WB_HAZARD_EN adds the hazard comparators; when it is not
// defined the hazard outputs are tied low and the query inputs are ignored.

module xc_rf_wb_arb #(
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        p_valid,
   output logic        p_ready,
   input  logic [4:0]  p_addr,
   input  logic [31:0] p_wdata,
   input  logic        c_valid,
   output logic        c_ready,
   input  logic        c_wide,
   input  logic [4:0]  c_addr,
   input  logic [31:0] c_wdata,
   input  logic [31:0] c_wdata_hi,
   output logic        rd_wen,
   output logic        rd_wide,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_wdata,
   output logic [31:0] rd_wdata_hi,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic        rs1_hazard,
   output logic        rs2_hazard,
   output logic        wide_misalign
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   typedef struct packed {
      logic        wide;
      logic [4:0]  addr;
      logic [31:0] hi;
      logic [31:0] lo;
   } entry_t;

   entry_t      fifo_q [2];
   entry_t      fifo_d [2];
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [2:0]  starve_q, starve_d;
   logic        rd_wen_q, rd_wen_d;
   logic        rd_wide_q, rd_wide_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [31:0] rd_wdata_q, rd_wdata_d;
   logic [31:0] rd_wdata_hi_q, rd_wdata_hi_d;
   logic        misalign_q, misalign_d;

   logic        fifo_ne, forced, p_fire, c_fire, fifo_grant, wr_ptr;
   entry_t      head, c_entry;

   // Arbitration: ready signals come from registered state only, gated low in reset.
   always_comb begin
      fifo_ne      = (count_q != 2'd0);
      forced       = fifo_ne && (starve_q == LIMIT);
      p_ready      = resetn && !forced;
      c_ready      = resetn && (count_q < 2'd2);
      p_fire       = p_valid && p_ready;
      c_fire       = c_valid && c_ready;
      // FIFO head wins whenever the pipeline does not fire (forced or idle).
      fifo_grant   = fifo_ne && !p_fire;
      head         = fifo_q[rd_ptr_q];
      // Write slot is the one after the head; only meaningful while count < 2.
      wr_ptr       = rd_ptr_q ^ count_q[0];
      // Wide writes are forced onto an even register pair; narrow writes carry no high word.
      c_entry.wide = c_wide;
      c_entry.addr = c_wide ? {c_addr[4:1], 1'b0} : c_addr;
      c_entry.hi   = c_wide ? c_wdata_hi : 32'd0;
      c_entry.lo   = c_wdata;
   end

   always_comb begin
      fifo_d        = fifo_q;
      rd_wide_d     = rd_wide_q;
      rd_addr_d     = rd_addr_q;
      rd_wdata_d    = rd_wdata_q;
      rd_wdata_hi_d = rd_wdata_hi_q;
      rd_wen_d      = 1'b0;

      if (c_fire) begin
         fifo_d[wr_ptr] = c_entry;
      end
      count_d    = count_q + {1'b0, c_fire} - {1'b0, fifo_grant};
      rd_ptr_d   = rd_ptr_q ^ fifo_grant;
      starve_d   = (fifo_ne && !fifo_grant) ? starve_q + 3'd1 : 3'd0;
      misalign_d = misalign_q | (c_fire & c_wide & c_addr[0]);

      // A narrow write to r0 is consumed but never reaches the register file.
      if (p_fire) begin
         rd_wen_d      = (p_addr != 5'd0);
         rd_wide_d     = 1'b0;
         rd_addr_d     = p_addr;
         rd_wdata_d    = p_wdata;
         rd_wdata_hi_d = 32'd0;
      end else if (fifo_grant) begin
         rd_wen_d      = head.wide || (head.addr != 5'd0);
         rd_wide_d     = head.wide;
         rd_addr_d     = head.addr;
         rd_wdata_d    = head.lo;
         rd_wdata_hi_d = head.hi;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         fifo_q[0]     <= '0;
         fifo_q[1]     <= '0;
         count_q       <= 2'd0;
         rd_ptr_q      <= 1'b0;
         starve_q      <= 3'd0;
         rd_wen_q      <= 1'b0;
         rd_wide_q     <= 1'b0;
         rd_addr_q     <= 5'd0;
         rd_wdata_q    <= 32'd0;
         rd_wdata_hi_q <= 32'd0;
         misalign_q    <= 1'b0;
      end else begin
         fifo_q        <= fifo_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         starve_q      <= starve_d;
         rd_wen_q      <= rd_wen_d;
         rd_wide_q     <= rd_wide_d;
         rd_addr_q     <= rd_addr_d;
         rd_wdata_q    <= rd_wdata_d;
         rd_wdata_hi_q <= rd_wdata_hi_d;
         misalign_q    <= misalign_d;
      end
   end

   assign rd_wen        = rd_wen_q;
   assign rd_wide       = rd_wide_q;
   assign rd_addr       = rd_addr_q;
   assign rd_wdata      = rd_wdata_q;
   assign rd_wdata_hi   = rd_wdata_hi_q;
   assign wide_misalign = misalign_q;

`ifdef XC_RF_WB_HAZARD_EN
   // A wide write covers its even register and the odd register above it.
   function automatic logic writes_reg(input logic wide, input logic [4:0] addr,
                                       input logic [4:0] rs);
      return (rs == addr) || (wide && (rs == {addr[4:1], 1'b1}));
   endfunction

   logic [1:0] slot_v;

   always_comb begin
      slot_v[0]  = (count_q == 2'd2) || ((count_q == 2'd1) && !rd_ptr_q);
      slot_v[1]  = (count_q == 2'd2) || ((count_q == 2'd1) && rd_ptr_q);
      rs1_hazard = resetn && (rs1_addr != 5'd0) && (
                   (slot_v[0] && writes_reg(fifo_q[0].wide, fifo_q[0].addr, rs1_addr)) ||
                   (slot_v[1] && writes_reg(fifo_q[1].wide, fifo_q[1].addr, rs1_addr)) ||
                   (rd_wen_q  && writes_reg(rd_wide_q, rd_addr_q, rs1_addr)));
      rs2_hazard = resetn && (rs2_addr != 5'd0) && (
                   (slot_v[0] && writes_reg(fifo_q[0].wide, fifo_q[0].addr, rs2_addr)) ||
                   (slot_v[1] && writes_reg(fifo_q[1].wide, fifo_q[1].addr, rs2_addr)) ||
                   (rd_wen_q  && writes_reg(rd_wide_q, rd_addr_q, rs2_addr)));
   end
`else
   logic unused_rs;

   assign unused_rs  = ^{rs1_addr, rs2_addr};
   assign rs1_hazard = 1'b0;
   assign rs2_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_xc_rf_wb_arb.sv
// tb/tb_xc_rf_wb_arb.sv - self-checking bench for xc_rf_wb_arb
module tb_xc_rf_wb_arb;

   localparam int LIMIT = 3;
`ifdef XC_RF_WB_HAZARD_EN
   localparam bit HZ_EN = 1'b1;
`else
   localparam bit HZ_EN = 1'b0;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        resetn;
   logic        p_valid, p_ready;
   logic [4:0]  p_addr;
   logic [31:0] p_wdata;
   logic        c_valid, c_ready, c_wide;
   logic [4:0]  c_addr;
   logic [31:0] c_wdata, c_wdata_hi;
   logic        rd_wen, rd_wide;
   logic [4:0]  rd_addr;
   logic [31:0] rd_wdata, rd_wdata_hi;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        rs1_hazard, rs2_hazard, wide_misalign;

   xc_rf_wb_arb #(.STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .resetn(resetn),
      .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr), .p_wdata(p_wdata),
      .c_valid(c_valid), .c_ready(c_ready), .c_wide(c_wide), .c_addr(c_addr),
      .c_wdata(c_wdata), .c_wdata_hi(c_wdata_hi),
      .rd_wen(rd_wen), .rd_wide(rd_wide), .rd_addr(rd_addr),
      .rd_wdata(rd_wdata), .rd_wdata_hi(rd_wdata_hi),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard),
      .wide_misalign(wide_misalign)
   );

   typedef struct {
      logic        wide;
      logic [4:0]  addr;
      logic [31:0] lo;
      logic [31:0] hi;
   } wr_t;

   typedef struct {
      bit          cop;
      bit          wide;
      logic [4:0]  addr;
      logic [31:0] lo;
      logic [31:0] hi;
      bit          exp_wen;
      logic [4:0]  exp_addr;
      logic [31:0] exp_hi;
   } vec_t;

   vec_t        tab [7];
   wr_t         mq [$];
   int          m_starve;
   logic        m_wen, m_wide, m_mis;
   logic [4:0]  m_addr;
   logic [31:0] m_lo, m_hi;
   bit          last_pf, last_cf;
   int          n_pass = 0;
   int          n_total = 0;
   int          k;

   task automatic check_b(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%b expected=%b", name, act, exp);
   endtask

   task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h expected=%h", name, act, exp);
   endtask

   function automatic bit covers(input wr_t e, input logic [4:0] r);
      return (r == e.addr) || (e.wide && (r == e.addr + 5'd1));
   endfunction

   function automatic bit exp_haz(input logic [4:0] r);
      wr_t pend;
      bit  h = 1'b0;
      if (r == 5'd0) return 1'b0;
      foreach (mq[i]) if (covers(mq[i], r)) h = 1'b1;
      pend.wide = m_wide;
      pend.addr = m_addr;
      pend.lo   = 32'd0;
      pend.hi   = 32'd0;
      if (m_wen && covers(pend, r)) h = 1'b1;
      return h & HZ_EN;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_starve = 0;
      m_wen = 1'b0; m_wide = 1'b0; m_mis = 1'b0;
      m_addr = 5'd0; m_lo = 32'd0; m_hi = 32'd0;
      last_pf = 1'b0; last_cf = 1'b0;
   endtask

   task automatic idle();
      p_valid = 1'b0;
      c_valid = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check_b({tag, "_p_ready"}, p_ready, 1'b0);
      check_b({tag, "_c_ready"}, c_ready, 1'b0);
      check_b({tag, "_rs1_hazard"}, rs1_hazard, 1'b0);
      check_b({tag, "_rs2_hazard"}, rs2_hazard, 1'b0);
      check_b({tag, "_rd_wen"}, rd_wen, 1'b0);
      check_b({tag, "_rd_wide"}, rd_wide, 1'b0);
      check_w({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      check_w({tag, "_rd_wdata"}, rd_wdata, 32'd0);
      check_w({tag, "_rd_wdata_hi"}, rd_wdata_hi, 32'd0);
      check_b({tag, "_wide_misalign"}, wide_misalign, 1'b0);
   endtask

   // One clock of the reference model: called shortly after a rising edge with
   // the inputs for the coming cycle already applied.
   task automatic cycle();
      bit  forced, pf, cf, gf;
      int  sz;
      wr_t e;
      #1;
      sz     = mq.size();
      forced = (sz > 0) && (m_starve == LIMIT);
      check_b("p_ready", p_ready, !forced);
      check_b("c_ready", c_ready, sz < 2);
      check_b("rs1_hazard", rs1_hazard, exp_haz(rs1_addr));
      check_b("rs2_hazard", rs2_hazard, exp_haz(rs2_addr));
      pf = p_valid && !forced;
      cf = c_valid && (sz < 2);
      gf = (sz > 0) && !pf;
      if (pf) begin
         m_wen = (p_addr != 5'd0); m_wide = 1'b0; m_addr = p_addr;
         m_lo = p_wdata; m_hi = 32'd0;
      end else if (gf) begin
         e = mq.pop_front();
         m_wen = e.wide || (e.addr != 5'd0); m_wide = e.wide; m_addr = e.addr;
         m_lo = e.lo; m_hi = e.hi;
      end else begin
         m_wen = 1'b0;
      end
      m_starve = (sz > 0 && !gf) ? m_starve + 1 : 0;
      if (cf) begin
         e.wide = c_wide;
         e.addr = c_addr;
         if (c_wide && c_addr[0]) begin
            e.addr = c_addr - 5'd1;
            m_mis  = 1'b1;
         end
         e.lo = c_wdata;
         e.hi = c_wide ? c_wdata_hi : 32'd0;
         mq.push_back(e);
      end
      last_pf = pf;
      last_cf = cf;
      @(posedge clock);
      #1;
      check_b("rd_wen", rd_wen, m_wen);
      if (m_wen) begin
         check_b("rd_wide", rd_wide, m_wide);
         check_w("rd_addr", 32'(rd_addr), 32'(m_addr));
         check_w("rd_wdata", rd_wdata, m_lo);
         check_w("rd_wdata_hi", rd_wdata_hi, m_hi);
      end
      check_b("wide_misalign", wide_misalign, m_mis);
   endtask

   initial begin
      resetn = 1'b1;
      idle();
      p_addr = 5'd0; p_wdata = 32'd0;
      c_wide = 1'b0; c_addr = 5'd0; c_wdata = 32'd0; c_wdata_hi = 32'd0;
      rs1_addr = 5'd0; rs2_addr = 5'd0;
      model_reset();
      #1 resetn = 1'b0;
      #1 check_reset("por");
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;

      // Single writes from idle: {cop, wide, addr, lo, hi, exp_wen, exp_addr, exp_hi}
      tab[0] = '{1'b0, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0,        1'b1, 5'd5,  32'h0};
      tab[1] = '{1'b0, 1'b0, 5'd0,  32'h12345678, 32'h0,        1'b0, 5'd0,  32'h0};
      tab[2] = '{1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 32'h0,        1'b1, 5'd31, 32'h0};
      tab[3] = '{1'b1, 1'b1, 5'd6,  32'h11111111, 32'h22222222, 1'b1, 5'd6,  32'h22222222};
      tab[4] = '{1'b1, 1'b0, 5'd0,  32'h0BAD0BAD, 32'h0BAD0BAD, 1'b0, 5'd0,  32'h0};
      tab[5] = '{1'b1, 1'b0, 5'd3,  32'hAAAA5555, 32'hBBBBBBBB, 1'b1, 5'd3,  32'h0};
      tab[6] = '{1'b1, 1'b1, 5'd0,  32'h00000001, 32'h00000002, 1'b1, 5'd0,  32'h00000002};

      for (int i = 0; i < 7; i++) begin
         if (tab[i].cop) begin
            c_valid = 1'b1; c_wide = tab[i].wide; c_addr = tab[i].addr;
            c_wdata = tab[i].lo; c_wdata_hi = tab[i].hi;
         end else begin
            p_valid = 1'b1; p_addr = tab[i].addr; p_wdata = tab[i].lo;
         end
         cycle();
         idle();
         if (tab[i].cop) begin
            check_b("tab_c_early", rd_wen, 1'b0);
            cycle();
         end
         check_b("tab_wen", rd_wen, tab[i].exp_wen);
         if (tab[i].exp_wen) begin
            check_b("tab_wide", rd_wide, tab[i].wide);
            check_w("tab_addr", 32'(rd_addr), 32'(tab[i].exp_addr));
            check_w("tab_lo", rd_wdata, tab[i].lo);
            check_w("tab_hi", rd_wdata_hi, tab[i].exp_hi);
         end
         cycle();
      end

      // Wide write and the hazard on its odd half until commit.
      rs1_addr = 5'd7; rs2_addr = 5'd6;
      c_valid = 1'b1; c_wide = 1'b1; c_addr = 5'd6;
      c_wdata = 32'h11111111; c_wdata_hi = 32'h22222222;
      cycle();
      idle();
      check_b("wide_lat_early", rd_wen, 1'b0);
      check_b("wide_haz_fifo", rs1_hazard, HZ_EN);
      cycle();
      check_b("wide_wen", rd_wen, 1'b1);
      check_b("wide_wide", rd_wide, 1'b1);
      check_w("wide_addr", 32'(rd_addr), 32'd6);
      check_w("wide_lo", rd_wdata, 32'h11111111);
      check_w("wide_hi", rd_wdata_hi, 32'h22222222);
      check_b("wide_haz_pend", rs1_hazard, HZ_EN);
      cycle();
      check_b("wide_haz_clear", rs1_hazard, 1'b0);
      rs1_addr = 5'd0; rs2_addr = 5'd0;

      // Pipeline held busy while three coprocessor writes are offered.
      p_valid = 1'b1; p_addr = 5'd10; p_wdata = 32'h00000A0A;
      c_valid = 1'b1; c_wide = 1'b0; c_addr = 5'd12; c_wdata = 32'h000000C0;
      k = 0;
      for (int i = 0; i < 6; i++) begin
         check_b("starve_p_ready", p_ready, (i == 4) ? 1'b0 : 1'b1);
         check_b("starve_c_ready", c_ready, (i >= 2 && i <= 4) ? 1'b0 : 1'b1);
         cycle();
         if (last_cf) begin
            k++;
            c_addr  = 5'(12 + k);
            c_wdata = 32'(k);
            if (k == 3) c_valid = 1'b0;
         end
         if (i == 3) check_w("starve_p_win", 32'(rd_addr), 32'd10);
         if (i == 4) begin
            check_b("starve_grant", rd_wen, 1'b1);
            check_w("starve_head", 32'(rd_addr), 32'd12);
         end
      end
      idle();
      repeat (4) cycle();

      // Misaligned wide write.
      c_valid = 1'b1; c_wide = 1'b1; c_addr = 5'd9;
      c_wdata = 32'h99990000; c_wdata_hi = 32'h99990001;
      cycle();
      idle();
      cycle();
      check_w("misalign_addr", 32'(rd_addr), 32'd8);
      check_b("misalign_wide", rd_wide, 1'b1);
      check_b("misalign_flag", wide_misalign, 1'b1);
      repeat (3) cycle();
      check_b("misalign_sticky", wide_misalign, 1'b1);

      // Randomized traffic; senders hold payload while waiting.
      for (int n = 0; n < 3000; n++) begin
         if (!(p_valid && !last_pf)) begin
            p_valid = ($urandom_range(0, 99) < 60);
            p_addr  = 5'($urandom_range(0, 7));
            p_wdata = $urandom();
         end
         if (!(c_valid && !last_cf)) begin
            c_valid    = ($urandom_range(0, 99) < 50);
            c_wide     = 1'($urandom_range(0, 1));
            c_addr     = 5'($urandom_range(0, 7));
            c_wdata    = $urandom();
            c_wdata_hi = $urandom();
         end
         rs1_addr = 5'($urandom_range(0, 9));
         rs2_addr = 5'($urandom_range(0, 9));
         cycle();
      end
      idle();
      repeat (6) cycle();

      // Reset with two FIFO entries in flight.
      p_valid = 1'b1; p_addr = 5'd4; p_wdata = 32'h44444444;
      c_valid = 1'b1; c_wide = 1'b0; c_addr = 5'd20; c_wdata = 32'h20202020;
      cycle();
      c_addr = 5'd21; c_wdata = 32'h21212121;
      cycle();
      rs1_addr = 5'd20; rs2_addr = 5'd21;
      check_b("full_c_ready", c_ready, 1'b0);
      resetn = 1'b0;
      model_reset();
      #1 check_reset("async");
      @(posedge clock);
      #1 check_reset("held");
      idle();
      resetn = 1'b1;
      #1 check_b("release_c_ready", c_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_b("post_reset_no_wen", rd_wen, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
